// File: rtl/serial_adder_pkg.sv
// Shared encodings for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int SA_STW = 2;

  typedef enum logic [SA_STW-1:0] {
    SA_IDLE = 2'b00,
    SA_RUN  = 2'b01,
    SA_DONE = 2'b10
  } sa_state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder_cell.sv
// One-bit full adder built from two half adders; the single arithmetic cell
// that the serial controller reuses for every bit position.
module Half_Adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s0;
  logic c0;
  logic c1;

  Half_Adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  Half_Adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: feeds one full-adder cell LSB first over WIDTH
// cycles, with a start/done handshake and a held result register.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sa_state_t        state;
  sa_state_t        next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  full_adder_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign accept   = start && ((state == SA_IDLE) || (state == SA_DONE));
  assign last_bit = (count == CW'(WIDTH - 1));
  // New sum bit enters at the MSB; after WIDTH shifts the LSB result sits at bit 0.
  assign s_next   = (s_sh >> 1) | {fa_s, {(WIDTH-1){1'b0}}};

  assign busy = (state == SA_RUN);
  assign done = (state == SA_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SA_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = SA_IDLE;
    case (state)
      SA_IDLE: next_state = start ? SA_RUN : SA_IDLE;
      SA_RUN:  next_state = last_bit ? SA_DONE : SA_RUN;
      SA_DONE: next_state = start ? SA_RUN : SA_IDLE;
      default: next_state = SA_IDLE;
    endcase
  end

  // sum/cout only load on the final bit, so the previous result stays visible during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      count <= '0;
    end else if (state == SA_RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_next;
      carry <= fa_cout;
      count <= count + CW'(1);
      if (last_bit) begin
        sum  <= s_next;
        cout <= fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: a vector table on an 8-bit instance,
// hand-written corner sequences, and a 2-bit instance for the narrowest width.
module tb_serial_adder_ctrl;

  localparam int W  = 8;
  localparam int W2 = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, cin;
  logic [W-1:0]  a, b, sum;
  logic          busy, done, cout;
  logic          rst2_n, start2, cin2;
  logic [W2-1:0] a2, b2, sum2;
  logic          busy2, done2, cout2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(W2)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    bit           back2back;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge: one rising edge accepts the request, then operands are scrambled.
  task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic vcin);
    start = 1'b1;
    a     = va;
    b     = vb;
    cin   = vcin;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  task automatic waitDone(input logic [W-1:0] held_sum, output int busy_cycles,
                          output bit held_ok, output bit timed_out);
    int n;
    busy_cycles = 0;
    held_ok     = 1'b1;
    timed_out   = 1'b0;
    n           = 0;
    while (!done && n < 40) begin
      if (busy) busy_cycles++;
      if (sum !== held_sum) held_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    if (!done) timed_out = 1'b1;
  endtask

  initial begin
    int           bc;
    bit           held_ok;
    bit           to;
    int           t1;
    int           t2;
    int           n;
    bit           seen;
    logic [W-1:0] prev_sum;
    logic [W2-1:0] va2 [3];
    logic [W2-1:0] vb2 [3];
    logic          vc2 [3];
    logic [W2-1:0] es2 [3];
    logic          ec2 [3];

    vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

    va2[0] = 2'b11; vb2[0] = 2'b01; vc2[0] = 1'b0; es2[0] = 2'b00; ec2[0] = 1'b1;
    va2[1] = 2'b10; vb2[1] = 2'b01; vc2[1] = 1'b1; es2[1] = 2'b00; ec2[1] = 1'b1;
    va2[2] = 2'b01; vb2[2] = 2'b01; vc2[2] = 1'b0; es2[2] = 2'b10; ec2[2] = 1'b0;

    rst_n  = 1'b0; start  = 1'b0; a  = '0; b  = '0; cin  = 1'b0;
    rst2_n = 1'b0; start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_sum",  64'(sum),  64'd0);
    checkOutput("reset_cout", 64'(cout), 64'd0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    @(negedge clk);

    $display("[TB] vector table");
    prev_sum = '0;
    for (int i = 0; i < 7; i++) begin
      if (!vecs[i].back2back) begin
        @(negedge clk);
        checkOutput($sformatf("v%0d_idle_busy", i), 64'(busy), 64'd0);
        checkOutput($sformatf("v%0d_idle_done", i), 64'(done), 64'd0);
      end
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
      waitDone(prev_sum, bc, held_ok, to);
      checkOutput($sformatf("v%0d_timeout", i),  64'(to),      64'd0);
      checkOutput($sformatf("v%0d_busy_cyc", i), 64'(bc),      64'd8);
      checkOutput($sformatf("v%0d_sum_held", i), 64'(held_ok), 64'd1);
      checkOutput($sformatf("v%0d_done", i),     64'(done),    64'd1);
      checkOutput($sformatf("v%0d_sum", i),      64'(sum),     64'(vecs[i].exp_sum));
      checkOutput($sformatf("v%0d_cout", i),     64'(cout),    64'(vecs[i].exp_cout));
      prev_sum = vecs[i].exp_sum;
    end
    @(negedge clk);

    $display("[TB] start re-pulsed during RUN");
    applyStimulus(8'h3C, 8'h0F, 1'b0);
    n = 1;
    t1 = 0;
    while (!done && t1 < 40) begin
      start = (n == 3);
      if (n == 3) begin
        a = 8'h00;
        b = 8'h00;
      end
      t1++;
      @(negedge clk);
      if (busy) n++;
    end
    start = 1'b0;
    checkOutput("repulse_done",     64'(done), 64'd1);
    checkOutput("repulse_busy_cyc", 64'(n),    64'd8);
    checkOutput("repulse_sum",      64'(sum),  64'h4B);
    checkOutput("repulse_cout",     64'(cout), 64'd0);
    @(negedge clk);
    checkOutput("repulse_no_requeue", 64'(busy), 64'd0);

    $display("[TB] start held high across DONE");
    @(negedge clk);
    start = 1'b1; a = 8'h3C; b = 8'h0F; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 8'h01;
    b = 8'h02;
    n = 0;
    while (!done && n < 40) begin n++; @(negedge clk); end
    t1 = cyc;
    checkOutput("held_first_done", 64'(done), 64'd1);
    checkOutput("held_first_sum",  64'(sum),  64'h4B);
    @(negedge clk);
    checkOutput("held_busy_next", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 40) begin n++; @(negedge clk); end
    t2 = cyc;
    start = 1'b0;
    checkOutput("held_second_done", 64'(done),    64'd1);
    checkOutput("held_gap",         64'(t2 - t1), 64'd9);
    checkOutput("held_second_sum",  64'(sum),     64'h03);
    checkOutput("held_second_cout", 64'(cout),    64'd0);
    @(negedge clk);

    $display("[TB] reset during RUN");
    applyStimulus(8'hAA, 8'h55, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("rstrun_busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstrun_busy", 64'(busy), 64'd0);
    checkOutput("rstrun_done", 64'(done), 64'd0);
    checkOutput("rstrun_sum",  64'(sum),  64'd0);
    checkOutput("rstrun_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checkOutput("rstrun_no_done", 64'(seen), 64'd0);

    $display("[TB] WIDTH=2 instance");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start2 = 1'b1; a2 = va2[i]; b2 = vb2[i]; cin2 = vc2[i];
      @(negedge clk);
      t1 = cyc;
      start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0;
      n = 0;
      while (!done2 && n < 20) begin n++; @(negedge clk); end
      t2 = cyc;
      checkOutput($sformatf("w2_v%0d_done", i),    64'(done2),   64'd1);
      checkOutput($sformatf("w2_v%0d_latency", i), 64'(t2 - t1), 64'd2);
      checkOutput($sformatf("w2_v%0d_sum", i),     64'(sum2),    64'(es2[i]));
      checkOutput($sformatf("w2_v%0d_cout", i),    64'(cout2),   64'(ec2[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
